// File: rtl/unary_decode.sv
// Two-lane serial unary (thermometer) decoder: counts the ones on each lane over a
// fixed-length frame, flags non-thermometer streams, and hands results over via Done/Ack.
module unary_decode #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic             unary0_in,
  input  logic             unary1_in,
  output logic [WIDTH-1:0] bin0,
  output logic [WIDTH-1:0] bin1,
  output logic             err0,
  output logic             err1,
  output logic             Busy,
  output logic             Done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Index of the final sample within a frame; the frame counter never exceeds FRAME_LEN.
  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(FRAME_LEN - 1);

  if (FRAME_LEN < 1 || FRAME_LEN > (2 ** WIDTH) - 1) begin : g_bad_frame_len
    $error("unary_decode: FRAME_LEN must lie in 1 .. 2**WIDTH-1");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cnt0;
  logic [WIDTH-1:0] r_cnt1;
  logic [WIDTH-1:0] r_frame;
  logic             r_seen0;
  logic             r_seen1;
  logic             r_err0;
  logic             r_err1;

  logic [WIDTH-1:0] w_cnt0Next;
  logic [WIDTH-1:0] w_cnt1Next;
  logic             w_err0Next;
  logic             w_err1Next;
  logic             w_lastSample;

  // A one arriving after this lane has already seen a zero breaks the thermometer code.
  assign w_cnt0Next   = r_cnt0 + {{(WIDTH-1){1'b0}}, unary0_in};
  assign w_cnt1Next   = r_cnt1 + {{(WIDTH-1){1'b0}}, unary1_in};
  assign w_err0Next   = r_err0 | (r_seen0 & unary0_in);
  assign w_err1Next   = r_err1 | (r_seen1 & unary1_in);
  assign w_lastSample = (r_frame == LAST_IDX);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_frame <= '0;
      r_seen0 <= 1'b0;
      r_seen1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      bin0    <= '0;
      bin1    <= '0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_COUNT;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
            r_frame <= '0;
            r_seen0 <= 1'b0;
            r_seen1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            Busy    <= 1'b1;
          end
        end

        S_COUNT: begin
          r_cnt0  <= w_cnt0Next;
          r_cnt1  <= w_cnt1Next;
          r_frame <= r_frame + 1'b1;
          r_seen0 <= r_seen0 | ~unary0_in;
          r_seen1 <= r_seen1 | ~unary1_in;
          r_err0  <= w_err0Next;
          r_err1  <= w_err1Next;
          if (w_lastSample) begin
            bin0    <= w_cnt0Next;
            bin1    <= w_cnt1Next;
            err0    <= w_err0Next;
            err1    <= w_err1Next;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // Start alone is ignored so unread results are never overwritten.
          if (Ack) begin
            Done <= 1'b0;
            if (Start) begin
              r_state <= S_COUNT;
              r_cnt0  <= '0;
              r_cnt1  <= '0;
              r_frame <= '0;
              r_seen0 <= 1'b0;
              r_seen1 <= 1'b0;
              r_err0  <= 1'b0;
              r_err1  <= 1'b0;
              Busy    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unary_decode.sv
// Directed bench for unary_decode: drives thermometer and broken frames on both lanes
// and checks counts, error flags, handshake timing and asynchronous reset.
module tb_unary_decode;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 255;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic             Ack = 1'b0;
  logic             unary0_in = 1'b0;
  logic             unary1_in = 1'b0;
  logic [WIDTH-1:0] bin0;
  logic [WIDTH-1:0] bin1;
  logic             err0;
  logic             err1;
  logic             Busy;
  logic             Done;

  int errors = 0;
  int checks = 0;

  int expBin0 = 0;
  int expBin1 = 0;
  int expErr0 = 0;
  int expErr1 = 0;

  unary_decode #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .unary0_in (unary0_in),
    .unary1_in (unary1_in),
    .bin0      (bin0),
    .bin1      (bin1),
    .err0      (err0),
    .err1      (err1),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #10 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_bin0"}, int'(bin0), expBin0);
    checkOutput({tag, "_bin1"}, int'(bin1), expBin1);
    checkOutput({tag, "_err0"}, int'(err0), expErr0);
    checkOutput({tag, "_err1"}, int'(err1), expErr1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bin0"}, int'(bin0), 0);
    checkOutput({tag, "_bin1"}, int'(bin1), 0);
    checkOutput({tag, "_err0"}, int'(err0), 0);
    checkOutput({tag, "_err1"}, int'(err1), 0);
    checkOutput({tag, "_busy"}, int'(Busy), 0);
    checkOutput({tag, "_done"}, int'(Done), 0);
  endtask

  // Runs one full frame. Lane bits on the Start edge are ones to prove they are not counted.
  // glitch0 replaces lane 0 with the broken pattern 1,1,0,1,0,0...
  task automatic applyStimulus(input string tag, input int n0, input int n1,
                               input bit glitch0, input bit withAck);
    @(negedge Clk);
    Start = 1'b1; Ack = withAck; unary0_in = 1'b1; unary1_in = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Ack = 1'b0;
    checkOutput({tag, "_busy_start"}, int'(Busy), 1);
    checkOutput({tag, "_done_start"}, int'(Done), 0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      unary0_in = glitch0 ? (i < 2 || i == 3) : (i < n0);
      unary1_in = (i < n1);
      @(negedge Clk);
      if (i == 100) checkHeld({tag, "_mid"});
      if (i == FRAME_LEN - 2) begin
        checkOutput({tag, "_done_early"}, int'(Done), 0);
        checkOutput({tag, "_busy_late"}, int'(Busy), 1);
      end
    end
    unary0_in = 1'b0; unary1_in = 1'b0;
    expBin0 = glitch0 ? 3 : n0;
    expBin1 = n1;
    expErr0 = glitch0 ? 1 : 0;
    expErr1 = 0;
    checkOutput({tag, "_done"}, int'(Done), 1);
    checkOutput({tag, "_busy_end"}, int'(Busy), 0);
    checkHeld(tag);
  endtask

  task automatic ackFrame(input string tag);
    @(negedge Clk);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    checkOutput({tag, "_ack_done"}, int'(Done), 0);
    checkOutput({tag, "_ack_busy"}, int'(Busy), 0);
    checkHeld({tag, "_ack"});
  endtask

  initial begin
    #3;
    checkAllZero("por");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    applyStimulus("f10_15", 10, 15, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput("hold_done", int'(Done), 1);
    end

    // Start without Ack in DONE must leave the unread results alone.
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    checkOutput("nack_done", int'(Done), 1);
    checkOutput("nack_busy", int'(Busy), 0);
    checkHeld("nack");

    applyStimulus("f112_150", 112, 150, 1'b0, 1'b1);
    ackFrame("f112_150");
    applyStimulus("f2_0", 2, 0, 1'b0, 1'b0);
    ackFrame("f2_0");
    applyStimulus("f255", 255, 255, 1'b0, 1'b0);
    ackFrame("f255");
    applyStimulus("fglitch", 0, 7, 1'b1, 1'b0);

    // Asynchronous reset while holding results in DONE.
    @(negedge Clk);
    #3 Reset = 1'b0;
    #1 checkAllZero("rst_done");
    expBin0 = 0; expBin1 = 0; expErr0 = 0; expErr1 = 0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Frame abandoned by reset after a stray Start mid-count.
    @(negedge Clk);
    Start = 1'b1; unary0_in = 1'b1; unary1_in = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      Start = (i == 40);
      @(negedge Clk);
      if (i == 40) checkOutput("stray_busy", int'(Busy), 1);
    end
    Start = 1'b0;
    #4 Reset = 1'b0;
    #1 checkAllZero("rst_count");
    @(negedge Clk);
    unary0_in = 1'b0; unary1_in = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    checkAllZero("rst_idle");

    applyStimulus("fresh", 20, 30, 1'b0, 1'b0);
    ackFrame("fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
